// File: rtl/aes_rx_sequencer.sv
// Receive-side sequencer: frames UART bytes into the SIPO/CRC16, launches AES, hands off to Tx.
// Optional inter-byte timeout is enabled by defining RX_TIMEOUT_EN.
module aes_rx_sequencer #(
  parameter int unsigned FRAME_BYTES    = 18,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_rx_valid,
  input  logic [7:0] i_rx_byte,
  output logic       o_sipo_shift,
  output logic [7:0] o_sipo_data,
  output logic       o_sipo_clear,
  output logic       o_crc_en,
  output logic       o_crc_clear,
  input  logic       i_crc_ok,
  output logic       o_aes_start,
  input  logic       i_aes_done,
  input  logic       i_tx_busy,
  output logic       o_tx_start,
  output logic       o_busy,
  output logic       o_frame_err,
  output logic       o_overrun
);

  typedef enum logic [2:0] {
    StIdle, StRecv, StCheck, StAesGo, StAesWait, StHandoff, StError
  } state_e;

  localparam logic [7:0] LP_LAST = 8'(FRAME_BYTES - 1);

  state_e     r_state;
  logic [7:0] r_cnt;
  logic       r_chk_wait;
  logic       r_sipo_shift;
  logic [7:0] r_sipo_data;
  logic       r_sipo_clear;
  logic       r_crc_en;
  logic       r_crc_clear;
  logic       r_aes_start;
  logic       r_tx_start;
  logic       r_busy;
  logic       r_frame_err;
  logic       r_overrun;
`ifdef RX_TIMEOUT_EN
  logic [31:0] r_gap;
`endif

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= StIdle;
      r_cnt        <= 8'd0;
      r_chk_wait   <= 1'b0;
      r_sipo_shift <= 1'b0;
      r_sipo_data  <= 8'd0;
      r_sipo_clear <= 1'b1;
      r_crc_en     <= 1'b0;
      r_crc_clear  <= 1'b1;
      r_aes_start  <= 1'b0;
      r_tx_start   <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
`ifdef RX_TIMEOUT_EN
      r_gap        <= 32'd0;
`endif
    end else begin
      r_sipo_shift <= 1'b0;
      r_crc_en     <= 1'b0;
      r_aes_start  <= 1'b0;
      r_tx_start   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= i_rx_valid && (r_state != StIdle) && (r_state != StRecv);

      unique case (r_state)
        StIdle: begin
          r_cnt <= 8'd0;
`ifdef RX_TIMEOUT_EN
          r_gap <= 32'd0;
`endif
          if (i_rx_valid) begin
            r_state      <= StRecv;
            r_sipo_data  <= i_rx_byte;
            r_sipo_shift <= 1'b1;
            r_crc_en     <= 1'b1;
            r_cnt        <= 8'd1;
            r_sipo_clear <= 1'b0;
            r_crc_clear  <= 1'b0;
            r_busy       <= 1'b1;
          end
        end
        StRecv: begin
          if (i_rx_valid) begin
            r_sipo_data  <= i_rx_byte;
            r_sipo_shift <= 1'b1;
            r_crc_en     <= 1'b1;
            r_cnt        <= r_cnt + 8'd1;
`ifdef RX_TIMEOUT_EN
            r_gap        <= 32'd0;
`endif
            if (r_cnt == LP_LAST) begin
              r_state    <= StCheck;
              r_chk_wait <= 1'b1;
            end
          end
`ifdef RX_TIMEOUT_EN
          else if (r_gap == 32'(TIMEOUT_CYCLES - 1)) begin
            r_state <= StError;
          end else begin
            r_gap <= r_gap + 32'd1;
          end
`endif
        end
        StCheck: begin
          // First cycle lets the CRC absorb the final byte; crc_ok is sampled on the second.
          if (r_chk_wait) begin
            r_chk_wait <= 1'b0;
          end else begin
            r_state <= i_crc_ok ? StAesGo : StError;
          end
        end
        StAesGo: begin
          r_aes_start <= 1'b1;
          r_state     <= StAesWait;
        end
        StAesWait: begin
          // A done level coincident with our own start pulse belongs to a stale result.
          if (i_aes_done && !r_aes_start) begin
            r_state <= StHandoff;
          end
        end
        StHandoff: begin
          if (!i_tx_busy) begin
            r_tx_start   <= 1'b1;
            r_state      <= StIdle;
            r_busy       <= 1'b0;
            r_sipo_clear <= 1'b1;
            r_crc_clear  <= 1'b1;
          end
        end
        StError: begin
          r_frame_err  <= 1'b1;
          r_state      <= StIdle;
          r_busy       <= 1'b0;
          r_sipo_clear <= 1'b1;
          r_crc_clear  <= 1'b1;
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_sipo_shift = r_sipo_shift;
  assign o_sipo_data  = r_sipo_data;
  assign o_sipo_clear = r_sipo_clear;
  assign o_crc_en     = r_crc_en;
  assign o_crc_clear  = r_crc_clear;
  assign o_aes_start  = r_aes_start;
  assign o_tx_start   = r_tx_start;
  assign o_busy       = r_busy;
  assign o_frame_err  = r_frame_err;
  assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_aes_rx_sequencer.sv
// Self-checking bench for aes_rx_sequencer: frame table, byte scoreboard, corner sequences.
module tb_aes_rx_sequencer;

  localparam int unsigned FB = 18;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'd0;
  logic       crc_ok = 1'b0;
  logic       aes_done = 1'b0;
  logic       tx_busy = 1'b0;
  logic       o_sipo_shift, o_sipo_clear, o_crc_en, o_crc_clear, o_aes_start;
  logic       o_tx_start, o_busy, o_frame_err, o_overrun;
  logic [7:0] o_sipo_data;

  always #5 clk = ~clk;

  aes_rx_sequencer #(
    .FRAME_BYTES   (FB),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst_n),
    .i_rx_valid  (rx_valid),
    .i_rx_byte   (rx_byte),
    .o_sipo_shift(o_sipo_shift),
    .o_sipo_data (o_sipo_data),
    .o_sipo_clear(o_sipo_clear),
    .o_crc_en    (o_crc_en),
    .o_crc_clear (o_crc_clear),
    .i_crc_ok    (crc_ok),
    .o_aes_start (o_aes_start),
    .i_aes_done  (aes_done),
    .i_tx_busy   (tx_busy),
    .o_tx_start  (o_tx_start),
    .o_busy      (o_busy),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun)
  );

  typedef struct {
    bit crc_ok;
    int aes_lat;   // 0: also raise aes_done together with aes_start
    int busy_cyc;  // cycles tx_busy is held after aes_done
    int n_ovr;     // bytes sent during AES_WAIT
    bit ovr_exit;  // byte sent on the HANDOFF->IDLE edge
    int exp_aes;
    int exp_tx;
    int exp_ferr;
    int exp_ovr;
  } frame_t;

  frame_t     recs[5];
  int         n_checks = 0;
  int         n_fail = 0;
  int         c_shift = 0, c_aes = 0, c_tx = 0, c_ferr = 0, c_ovr = 0;
  logic [7:0] sb_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Output monitor: pulse counters and byte scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_sipo_shift) begin
        c_shift++;
        check("crc_en_with_shift", int'(o_crc_en), 1);
        check("shift_has_expected_byte", int'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) check("sipo_data", int'(o_sipo_data), int'(sb_q.pop_front()));
      end
      if (o_aes_start) c_aes++;
      if (o_tx_start)  c_tx++;
      if (o_frame_err) c_ferr++;
      if (o_overrun)   c_ovr++;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit expect_shift);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_byte  = b;
    if (expect_shift) sb_q.push_back(b);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound, input string name);
    int i;
    i = 0;
    while (o_busy && i < bound) begin
      @(negedge clk);
      i++;
    end
    check(name, int'(o_busy), 0);
  endtask

  task automatic run_frame(input frame_t r, input int already);
    int b_shift, b_aes, b_tx, b_ferr, b_ovr, i, lat;
    b_shift = c_shift; b_aes = c_aes; b_tx = c_tx; b_ferr = c_ferr; b_ovr = c_ovr;
    crc_ok = r.crc_ok;
    lat = r.aes_lat;
    for (int k = already; k < int'(FB); k++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    if (r.crc_ok) begin
      i = 0;
      while (!o_aes_start && i < 20) begin
        @(negedge clk);
        i++;
      end
      check("aes_start_seen", int'(o_aes_start), 1);
      if (r.aes_lat == 0) begin
        aes_done = 1'b1;
        @(negedge clk);
        aes_done = 1'b0;
        repeat (4) @(negedge clk);
        check("early_done_no_tx", c_tx - b_tx, 0);
        check("early_done_still_busy", int'(o_busy), 1);
        lat = 3;
      end
      tx_busy = (r.busy_cyc > 0);
      for (int k = 0; k < r.n_ovr; k++) send_byte(8'($urandom_range(0, 255)), 1'b0);
      repeat (lat) @(negedge clk);
      aes_done = 1'b1;
      @(negedge clk);
      aes_done = 1'b0;
      if (r.busy_cyc > 0) begin
        repeat (r.busy_cyc) @(negedge clk);
        check("no_tx_while_busy", c_tx - b_tx, 0);
        tx_busy = 1'b0;
        if (r.ovr_exit) begin
          rx_valid = 1'b1;
          rx_byte  = 8'hA5;
        end
        @(negedge clk);
        rx_valid = 1'b0;
        check("tx_start_after_busy_falls", int'(o_tx_start), 1);
        if (r.ovr_exit) check("overrun_at_exit", int'(o_overrun), 1);
      end
    end
    wait_idle(100, "busy_returns_low");
    repeat (2) @(negedge clk);
    check("busy_stays_low", int'(o_busy), 0);
    check("shift_count", c_shift - b_shift, int'(FB) - already);
    check("aes_start_count", c_aes - b_aes, r.exp_aes);
    check("tx_start_count", c_tx - b_tx, r.exp_tx);
    check("frame_err_count", c_ferr - b_ferr, r.exp_ferr);
    check("overrun_count", c_ovr - b_ovr, r.exp_ovr);
    check("sipo_clear_idle", int'(o_sipo_clear), 1);
    check("crc_clear_idle", int'(o_crc_clear), 1);
    check("scoreboard_drained", sb_q.size(), 0);
  endtask

  initial begin
    int b_ferr, b_tx, i;
    //                 crc lat busy ovr exit  aes tx ferr ovr
    recs[0] = '{1'b1, 20,  0,   0, 1'b0,  1, 1, 0, 0};
    recs[1] = '{1'b0, 20,  0,   0, 1'b0,  0, 0, 1, 0};
    recs[2] = '{1'b1,  5,  0,   0, 1'b0,  1, 1, 0, 0};
    recs[3] = '{1'b1, 20, 50,   3, 1'b1,  1, 1, 0, 4};
    recs[4] = '{1'b1,  0,  0,   0, 1'b0,  1, 1, 0, 0};

    #1 rst_n = 1'b0;
    #1;
    check("rst_sipo_clear", int'(o_sipo_clear), 1);
    check("rst_crc_clear", int'(o_crc_clear), 1);
    check("rst_busy", int'(o_busy), 0);
    check("rst_sipo_shift", int'(o_sipo_shift), 0);
    check("rst_crc_en", int'(o_crc_en), 0);
    check("rst_aes_start", int'(o_aes_start), 0);
    check("rst_tx_start", int'(o_tx_start), 0);
    check("rst_frame_err", int'(o_frame_err), 0);
    check("rst_overrun", int'(o_overrun), 0);
    check("rst_sipo_data", int'(o_sipo_data), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_clears_held", int'(o_sipo_clear & o_crc_clear), 1);

    foreach (recs[k]) run_frame(recs[k], 0);

    // Reset in the middle of a frame, with no clock edge before the check.
    crc_ok = 1'b1;
    for (int k = 0; k < 9; k++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    check("midframe_busy", int'(o_busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", int'(o_busy), 0);
    check("async_rst_sipo_clear", int'(o_sipo_clear), 1);
    check("async_rst_crc_clear", int'(o_crc_clear), 1);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(recs[0], 0);

    // Stall after 5 bytes.
    b_ferr = c_ferr;
    b_tx   = c_tx;
    crc_ok = 1'b1;
    for (int k = 0; k < 5; k++) send_byte(8'($urandom_range(0, 255)), 1'b1);
`ifdef RX_TIMEOUT_EN
    i = 0;
    while (c_ferr == b_ferr && i < 80) begin
      @(negedge clk);
      i++;
    end
    check("timeout_frame_err", c_ferr - b_ferr, 1);
    check("timeout_idle", int'(o_busy), 0);
    check("timeout_no_tx", c_tx - b_tx, 0);
`else
    i = 0;
    repeat (200) @(negedge clk);
    check("stall_no_frame_err", c_ferr - b_ferr, 0);
    check("stall_busy", int'(o_busy), 1);
    run_frame(recs[0], 5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
